code_detector: RTL and testbench
================================

# code_detector

Moore finite-state machine that unlocks on a fixed colour-button code. Unlock requires a Start press followed by the exact sequence Red, Blue, Green, Red on consecutive clock cycles. It sits between the debounced, clock-synchronised keypad buttons (Start, Red, Green, Blue) and the lock actuator. Output U pulses high for exactly one cycle when the full code has been entered.

## Interface
- No parameters.
- Clk  input  1  system clock; all state changes on rising edge.
- Rst  input  1  asynchronous, active-low reset (Rst=0 forces reset immediately; released synchronously by the system).
- Start  input  1  start-of-code button, active-high, synchronous to Clk.
- Red  input  1  red button, active-high.
- Green  input  1  green button, active-high.
- Blue  input  1  blue button, active-high.
- U  output  1  unlock; high only in state S_Red2.
- Port order: Start, Red, Green, Blue, Clk, Rst, U.

## Operation
- States: S_Wait, S_Start, S_Red1, S_Blue, S_Green, S_Red2. Binary-encoded 3-bit state register. Unused encodings go to S_Wait.
- A state's "exact colour" means that colour is 1 and the other two colour buttons are 0.
- S_Wait: Start=1 -> S_Start; otherwise stay. Colour buttons are ignored.
- S_Start: exact Red -> S_Red1; any other colour combination (including 000) -> S_Wait.
- S_Red1: exact Blue -> S_Blue; else -> S_Wait.
- S_Blue: exact Green -> S_Green; else -> S_Wait.
- S_Green: exact Red -> S_Red2; else -> S_Wait.
- S_Red2: unconditionally -> S_Wait.
- Start is ignored in every state except S_Wait. A Start press mid-code does not restart the sequence.
- Each clock cycle consumes one input sample. There is no wait-on-idle: an all-zero sample in a code state aborts to S_Wait.
- U = (state == S_Red2). It is decoded from the state register only, with no input-to-output combinational path.

## Timing
- Reset: Rst=0 asynchronously sets state to S_Wait and U to 0. Reset mid-sequence aborts the code.
- Start sampled high at edge N gives S_Start after N.
- Colour samples at edges N+1..N+4 give S_Red2 after N+4 if all four are correct.
- U is high from just after edge N+4 until just after edge N+5, exactly one cycle.
- Minimum start-to-unlock latency is 5 rising edges.
- Once the FSM is back in S_Wait, a new attempt needs a fresh Start.
- Any wrong sample returns to S_Wait on that same edge. The earliest retry is a Start sampled at the next edge.

## Test plan
- Reset: hold Rst=0 mid-code (state S_Blue) -> state S_Wait immediately, without waiting for a clock edge; U=0.
- Correct code: Start=1 for one edge, then (R,G,B) = 100, 001, 010, 100 on four consecutive edges. Required response: U=1 for exactly the cycle after the 4th edge, then U=0 with state S_Wait.
- Exhaustive sweep: for all 4096 combinations of four 3-bit (R,G,B) samples after Start, U=1 only for 100_001_010_100 (slot0..slot3), i.e. bits[11:0] = 100_010_001_100 (index 2188) with slot0 in bits[2:0] as {R,G,B}. All other combinations give U=0.
- Multi-button abort: Start, then RGB=110 -> S_Wait; the remaining correct samples produce U=0.
- Idle abort: Start, Red, then 000 -> S_Wait; the following Green, Red produce U=0.
- No start: apply 100, 001, 010, 100 with Start=0 throughout -> U stays 0. Also: Start=1 held during code entry does not restart; the correct code still unlocks.

Source files
------------

// File: rtl/code_detector.sv
// Colour-button code lock: Start, then Red, Blue, Green, Red on consecutive
// cycles raises U for exactly one cycle.
//
// state   | meaning
// --------+---------------------------------------------
// S_Wait  | idle, waiting for a Start press
// S_Start | Start seen, expecting exact Red
// S_Red1  | Red accepted, expecting exact Blue
// S_Blue  | Blue accepted, expecting exact Green
// S_Green | Green accepted, expecting exact Red
// S_Red2  | full code entered, U asserted for this cycle
module code_detector (
    input  logic Start,
    input  logic Red,
    input  logic Green,
    input  logic Blue,
    input  logic Clk,
    input  logic Rst,
    output logic U
);

    typedef enum logic [2:0] {
        S_Wait  = 3'd0,
        S_Start = 3'd1,
        S_Red1  = 3'd2,
        S_Blue  = 3'd3,
        S_Green = 3'd4,
        S_Red2  = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;

    logic exact_red;
    logic exact_green;
    logic exact_blue;

    // A colour only counts when it is the sole colour button pressed.
    assign exact_red   =  Red & ~Green & ~Blue;
    assign exact_green = ~Red &  Green & ~Blue;
    assign exact_blue  = ~Red & ~Green &  Blue;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_Wait;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_Wait;
        unique case (state_q)
            S_Wait:  state_d = Start       ? S_Start : S_Wait;
            S_Start: state_d = exact_red   ? S_Red1  : S_Wait;
            S_Red1:  state_d = exact_blue  ? S_Blue  : S_Wait;
            S_Blue:  state_d = exact_green ? S_Green : S_Wait;
            S_Green: state_d = exact_red   ? S_Red2  : S_Wait;
            S_Red2:  state_d = S_Wait;
            default: state_d = S_Wait;
        endcase
    end

    // Moore output: decoded from the register only, no input path.
    assign U = (state_q == S_Red2);

endmodule

// File: tb/tb_code_detector.sv
// Directed self-checking bench for code_detector: reset, correct code,
// abort cases, held Start, and an exhaustive sweep of four colour samples.
module tb_code_detector;

    logic Start;
    logic Red;
    logic Green;
    logic Blue;
    logic Clk;
    logic Rst;
    logic U;

    int n_checks;
    int n_fail;

    code_detector dut (
        .Start (Start),
        .Red   (Red),
        .Green (Green),
        .Blue  (Blue),
        .Clk   (Clk),
        .Rst   (Rst),
        .U     (U)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Drive one sample, let it be taken at the next rising edge, settle #1.
    task automatic apply(input logic s, input logic r, input logic g, input logic b);
        Start = s;
        Red   = r;
        Green = g;
        Blue  = b;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [11:0] idx;
        logic [2:0]  slot;
        n_checks = 0;
        n_fail   = 0;
        Start = 0; Red = 0; Green = 0; Blue = 0;
        Rst = 1'b0;
        #2;
        check("reset_u", 32'(U), 0);
        check("reset_state", 32'(dut.state_q), 0);
        @(posedge Clk);
        #3;
        Rst = 1'b1;
        apply(0, 0, 0, 0);
        check("idle_u", 32'(U), 0);

        // Correct code
        apply(1, 0, 0, 0);
        check("code_start_u", 32'(U), 0);
        apply(0, 1, 0, 0);
        apply(0, 0, 0, 1);
        apply(0, 0, 1, 0);
        check("code_before_last_u", 32'(U), 0);
        apply(0, 1, 0, 0);
        check("code_unlock_u", 32'(U), 1);
        apply(0, 0, 0, 0);
        check("code_after_u", 32'(U), 0);
        check("code_after_state", 32'(dut.state_q), 0);

        // Multi-button abort
        apply(1, 0, 0, 0);
        apply(0, 1, 1, 0);
        apply(0, 0, 0, 1);
        apply(0, 0, 1, 0);
        apply(0, 1, 0, 0);
        check("multi_abort_u", 32'(U), 0);
        apply(0, 0, 0, 0);

        // Idle abort, then immediate retry on the following edge
        apply(1, 0, 0, 0);
        apply(0, 1, 0, 0);
        apply(0, 0, 0, 0);
        apply(0, 0, 1, 0);
        apply(0, 1, 0, 0);
        check("idle_abort_u", 32'(U), 0);
        apply(1, 0, 0, 0);
        apply(0, 0, 1, 0);
        check("wrong_then_wait", 32'(dut.state_q), 0);
        apply(1, 0, 0, 0);
        apply(0, 1, 0, 0);
        apply(0, 0, 0, 1);
        apply(0, 0, 1, 0);
        apply(0, 1, 0, 0);
        check("retry_unlock_u", 32'(U), 1);
        apply(0, 0, 0, 0);

        // No Start
        apply(0, 1, 0, 0);
        apply(0, 0, 0, 1);
        apply(0, 0, 1, 0);
        apply(0, 1, 0, 0);
        check("no_start_u", 32'(U), 0);
        apply(0, 0, 0, 0);
        check("no_start_after_u", 32'(U), 0);

        // Start held through code entry must not restart the sequence
        apply(1, 0, 0, 0);
        apply(1, 1, 0, 0);
        apply(1, 0, 0, 1);
        apply(1, 0, 1, 0);
        apply(1, 1, 0, 0);
        check("start_held_unlock_u", 32'(U), 1);
        apply(0, 0, 0, 0);
        check("start_held_after_u", 32'(U), 0);
        apply(0, 0, 0, 0);

        // Reset while in S_Blue aborts the code without a clock edge
        apply(1, 0, 0, 0);
        apply(0, 1, 0, 0);
        apply(0, 0, 0, 1);
        check("pre_reset_state", 32'(dut.state_q), 3);
        #2;
        Rst = 1'b0;
        #1;
        check("async_rst_state", 32'(dut.state_q), 0);
        check("async_rst_u", 32'(U), 0);
        #3;
        Rst = 1'b1;
        apply(0, 0, 1, 0);
        apply(0, 1, 0, 0);
        check("post_reset_code_u", 32'(U), 0);
        apply(0, 0, 0, 0);

        // Reset while U is high drops U immediately
        apply(1, 0, 0, 0);
        apply(0, 1, 0, 0);
        apply(0, 0, 0, 1);
        apply(0, 0, 1, 0);
        apply(0, 1, 0, 0);
        check("pre_reset_unlock_u", 32'(U), 1);
        #1;
        Rst = 1'b0;
        #1;
        check("async_rst_u_drop", 32'(U), 0);
        #1;
        Rst = 1'b1;
        apply(0, 0, 0, 0);

        // Exhaustive sweep over four 3-bit {R,G,B} samples, slot0 in idx[2:0]
        for (int i = 0; i < 4096; i++) begin
            idx = 12'(i);
            apply(1, 0, 0, 0);
            for (int k = 0; k < 4; k++) begin
                slot = idx[3*k +: 3];
                apply(0, slot[2], slot[1], slot[0]);
            end
            check($sformatf("sweep_%0d", i), 32'(U), (i == 2188) ? 1 : 0);
            apply(0, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
